// File: rtl/loader_pkg.sv
// Shared types and sizes for the byte-stream instruction loader.
package loader_pkg;

    localparam int unsigned BYTE_BITS      = 8;
    localparam int unsigned WORD_BITS      = 32;
    localparam int unsigned BYTES_PER_WORD = WORD_BITS / BYTE_BITS;
    localparam int unsigned BYTE_IDX_BITS  = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembly: byte index counter plus word register.
module word_assembler
    import loader_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     load,
    input  logic [BYTE_BITS-1:0]     in_byte,
    output logic [BYTE_IDX_BITS-1:0] byte_idx,
    output logic [WORD_BITS-1:0]     word
);

    // Index wraps naturally after the last byte of a word.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_idx <= '0;
        end else if (load) begin
            word[byte_idx*BYTE_BITS +: BYTE_BITS] <= in_byte;
            byte_idx                              <= byte_idx + BYTE_IDX_BITS'(1);
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Loads a program into instruction memory from a byte stream, one write per
// assembled 32-bit word, holding the CPU stalled while the load is active.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int unsigned I_ADDR_BITS      = 6,
    parameter int unsigned INSTRUCTION_SIZE = WORD_BITS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic [BYTE_BITS-1:0]        in_byte,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic                        mem_we,
    output logic [I_ADDR_BITS-1:0]      mem_addr,
    output logic [INSTRUCTION_SIZE-1:0] mem_wdata,
    output logic                        cpu_hold,
    output logic                        done,
    output logic                        error,
    output logic [I_ADDR_BITS:0]        word_count
);

    localparam int unsigned CNT_BITS = I_ADDR_BITS + 1;
    localparam logic [CNT_BITS-1:0] CAPACITY = {1'b1, {I_ADDR_BITS{1'b0}}};
    localparam logic [BYTE_IDX_BITS-1:0] LAST_IDX = BYTE_IDX_BITS'(BYTES_PER_WORD - 1);

    loader_state_t            state;
    logic                     last_q;
    logic                     accept;
    logic                     restart;
    logic [BYTE_IDX_BITS-1:0] byte_idx;

    assign accept  = in_valid && in_ready;
    assign restart = start && (state == IDLE || state == ERROR);

    word_assembler u_word_assembler (
        .clk      (clk),
        .reset    (reset),
        .clear    (restart),
        .load     (accept),
        .in_byte  (in_byte),
        .byte_idx (byte_idx),
        .word     (mem_wdata)
    );

    // mem_addr doubles as the running write address; it is only looked at during WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_q     <= 1'b0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            if (restart) begin
                state      <= RECV;
                in_ready   <= 1'b1;
                cpu_hold   <= 1'b1;
                error      <= 1'b0;
                mem_addr   <= '0;
                word_count <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                    end
                    RECV: begin
                        if (accept) begin
                            // Overflow and truncated words both abort without writing.
                            if ((byte_idx == '0 && word_count == CAPACITY) ||
                                (byte_idx != LAST_IDX && in_last)) begin
                                state    <= ERROR;
                                in_ready <= 1'b0;
                                error    <= 1'b1;
                            end else if (byte_idx == LAST_IDX) begin
                                state    <= WRITE;
                                in_ready <= 1'b0;
                                mem_we   <= 1'b1;
                                last_q   <= in_last;
                            end
                        end
                    end
                    WRITE: begin
                        mem_addr   <= mem_addr + I_ADDR_BITS'(1);
                        word_count <= word_count + CNT_BITS'(1);
                        if (last_q) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= RECV;
                            in_ready <= 1'b1;
                        end
                    end
                    DONE: begin
                        state    <= IDLE;
                        cpu_hold <= 1'b0;
                    end
                    ERROR: begin
                    end
                    default: begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        cpu_hold <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader with a 4-word memory (I_ADDR_BITS=2).
module tb_instruction_loader;

    localparam int unsigned ABITS = 2;

    typedef struct packed {
        logic [ABITS-1:0] addr;
        logic [31:0]      data;
    } wr_exp_t;

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic             start    = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_byte  = 8'h00;
    logic             in_last  = 1'b0;
    logic             in_ready;
    logic             mem_we;
    logic [ABITS-1:0] mem_addr;
    logic [31:0]      mem_wdata;
    logic             cpu_hold;
    logic             done;
    logic             error;
    logic [ABITS:0]   word_count;

    wr_exp_t     exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] prog[4];

    instruction_loader #(
        .I_ADDR_BITS      (ABITS),
        .INSTRUCTION_SIZE (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every mem_we must match the oldest expected write.
    always @(negedge clk) begin : mon
        wr_exp_t e;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk_eq("unexpected_write", 64'(mem_we), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk_eq("wr_addr", 64'(mem_addr), 64'(e.addr));
                chk_eq("wr_data", 64'(mem_wdata), 64'(e.data));
                chk_eq("wr_ready_low", 64'(in_ready), 64'(0));
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input logic last, input logic wr_next);
        int n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            chk_eq("accept_wait", 64'(in_ready), 64'(1));
        end else begin
            @(negedge clk);
            chk_eq("we_latency", 64'(mem_we), 64'(wr_next));
        end
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [ABITS-1:0] addr, input logic [31:0] data,
                             input logic last, input int max_gap);
        wr_exp_t e;
        for (int k = 0; k < 4; k++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                in_last  = 1'b1;
                start    = 1'($urandom);
                @(negedge clk);
            end
            start = 1'b0;
            if (k == 3) begin
                e.addr = addr;
                e.data = data;
                exp_q.push_back(e);
            end
            send_byte(data[8*k +: 8], last && (k == 3), k == 3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) prog[i] = $urandom;

        repeat (3) @(negedge clk);
        chk_eq("rst_in_ready", 64'(in_ready), 64'(0));
        chk_eq("rst_mem_we", 64'(mem_we), 64'(0));
        chk_eq("rst_cpu_hold", 64'(cpu_hold), 64'(0));
        chk_eq("rst_done", 64'(done), 64'(0));
        chk_eq("rst_error", 64'(error), 64'(0));
        chk_eq("rst_word_count", 64'(word_count), 64'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq("idle_ready", 64'(in_ready), 64'(0));

        // Single word
        do_start();
        chk_eq("t1_hold", 64'(cpu_hold), 64'(1));
        chk_eq("t1_ready", 64'(in_ready), 64'(1));
        send_word(2'd0, 32'h0000_2083, 1'b1, 0);
        @(negedge clk);
        chk_eq("t1_done", 64'(done), 64'(1));
        chk_eq("t1_count", 64'(word_count), 64'(1));
        chk_eq("t1_hold_done", 64'(cpu_hold), 64'(1));
        @(negedge clk);
        chk_eq("t1_done_pulse", 64'(done), 64'(0));
        chk_eq("t1_hold_idle", 64'(cpu_hold), 64'(0));

        // Four words back to back
        do_start();
        for (int w = 0; w < 4; w++) send_word(ABITS'(w), prog[w], w == 3, 0);
        @(negedge clk);
        chk_eq("t2_done", 64'(done), 64'(1));
        chk_eq("t2_count", 64'(word_count), 64'(4));
        @(negedge clk);

        // Early last
        do_start();
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        chk_eq("t3_error", 64'(error), 64'(1));
        chk_eq("t3_ready", 64'(in_ready), 64'(0));
        chk_eq("t3_hold", 64'(cpu_hold), 64'(1));
        repeat (3) @(negedge clk);
        chk_eq("t3_sticky", 64'(error), 64'(1));
        chk_eq("t3_count", 64'(word_count), 64'(0));
        do_start();
        chk_eq("t3_restart_err", 64'(error), 64'(0));
        chk_eq("t3_restart_rdy", 64'(in_ready), 64'(1));
        send_word(2'd0, 32'hDEAD_BEEF, 1'b1, 0);
        @(negedge clk);
        chk_eq("t3_done", 64'(done), 64'(1));
        chk_eq("t3_count_ok", 64'(word_count), 64'(1));
        @(negedge clk);

        // Overflow: fifth word aborts on its first byte
        do_start();
        for (int w = 0; w < 4; w++) send_word(ABITS'(w), ~prog[w], 1'b0, 0);
        send_byte(8'h55, 1'b0, 1'b0);
        chk_eq("t4_error", 64'(error), 64'(1));
        chk_eq("t4_ready", 64'(in_ready), 64'(0));
        chk_eq("t4_count", 64'(word_count), 64'(4));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_eq("t4_rst_error", 64'(error), 64'(0));
        chk_eq("t4_rst_hold", 64'(cpu_hold), 64'(0));

        // Throttled source, stray starts while busy
        do_start();
        send_word(2'd0, prog[0], 1'b0, 3);
        send_word(2'd1, prog[1], 1'b1, 3);
        start = 1'b0;
        @(negedge clk);
        chk_eq("t5_done", 64'(done), 64'(1));
        chk_eq("t5_count", 64'(word_count), 64'(2));
        @(negedge clk);

        // Reset mid-word
        do_start();
        send_byte(8'hA1, 1'b0, 1'b0);
        send_byte(8'hA2, 1'b0, 1'b0);
        send_byte(8'hA3, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_eq("t6_ready", 64'(in_ready), 64'(0));
        chk_eq("t6_we", 64'(mem_we), 64'(0));
        chk_eq("t6_hold", 64'(cpu_hold), 64'(0));
        chk_eq("t6_done", 64'(done), 64'(0));
        chk_eq("t6_error", 64'(error), 64'(0));
        chk_eq("t6_count", 64'(word_count), 64'(0));
        chk_eq("t6_addr", 64'(mem_addr), 64'(0));
        chk_eq("t6_wdata", 64'(mem_wdata), 64'(0));
        repeat (3) @(negedge clk);
        do_start();
        send_word(2'd0, 32'h1234_5678, 1'b1, 0);
        @(negedge clk);
        chk_eq("t6_done_ok", 64'(done), 64'(1));
        chk_eq("t6_count_ok", 64'(word_count), 64'(1));
        repeat (2) @(negedge clk);

        chk_eq("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
